fetch_unit: RTL

//   Instruction-fetch initiator for the instruction memory. Generates the word-aligned fetch

---
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch initiator. Drives the word-aligned fetch
//               address to an instruction memory with a fixed 1-cycle
//               registered read latency and hands {instruction, pc} to decode
//               over a valid/ready handshake. The output register and a
//               one-entry skid buffer absorb the word that is already in flight
//               when decode stalls. A redirect flushes everything and restarts
//               at the redirect target.
// Ports       : clk            - clock, rising edge
//               reset          - asynchronous, active-high reset
//               imem_addr      - fetch address to instruction memory
//               imem_rdata     - memory read data, valid 1 cycle after address
//               redirect_valid - branch/jump taken: flush and restart
//               redirect_pc    - redirect target (bits [1:0] ignored)
//               dec_valid      - dec_instr/dec_pc hold a valid instruction
//               dec_ready      - decode accepts (transfer on valid && ready)
//               dec_instr      - fetched instruction word
//               dec_pc         - address dec_instr was fetched from
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc
);

    localparam logic [31:0] c_pc_step = 32'(PC_STEP);

    // Fetch side
    logic [31:0] r_fetch_pc;
    logic        r_inflight_valid;
    logic [31:0] r_inflight_pc;

    // Output register and skid buffer
    logic        r_dec_valid;
    logic [31:0] r_dec_instr;
    logic [31:0] r_dec_pc;
    logic        r_skid_valid;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;

    // Combinational next-state
    logic        w_pop;
    logic [1:0]  w_occupancy;
    logic [1:0]  w_occ_after_pop;
    logic        w_issue;
    logic        w_dec_valid_nxt;
    logic [31:0] w_dec_instr_nxt;
    logic [31:0] w_dec_pc_nxt;
    logic        w_skid_valid_nxt;
    logic [31:0] w_skid_instr_nxt;
    logic [31:0] w_skid_pc_nxt;

    // The two low target bits are architecturally ignored.
    logic        w_unused_redirect_bits;
    assign w_unused_redirect_bits = ^redirect_pc[1:0];

    assign imem_addr = r_fetch_pc;
    assign dec_valid = r_dec_valid;
    assign dec_instr = r_dec_instr;
    assign dec_pc    = r_dec_pc;

    // Issue only when the word it fetches is guaranteed a slot: counting the
    // output register, the skid entry and the word already in flight (less
    // whatever leaves this cycle), at most one slot may be spoken for.
    always_comb begin
        w_pop           = r_dec_valid & dec_ready;
        w_occupancy     = {1'b0, r_dec_valid} + {1'b0, r_skid_valid}
                        + {1'b0, r_inflight_valid};
        w_occ_after_pop = w_occupancy - {1'b0, w_pop};
        w_issue         = !redirect_valid && (w_occ_after_pop < 2'd2);
    end

    // Output register / skid buffer steering. The skid entry is always older
    // than the arriving word, so it is promoted first to keep fetch order.
    always_comb begin
        w_dec_valid_nxt  = r_dec_valid;
        w_dec_instr_nxt  = r_dec_instr;
        w_dec_pc_nxt     = r_dec_pc;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_pc_nxt    = r_skid_pc;

        if (redirect_valid) begin
            // A same-cycle pop still completes; decode already owns that word.
            w_dec_valid_nxt  = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (!r_dec_valid || w_pop) begin
            if (r_skid_valid) begin
                w_dec_valid_nxt = 1'b1;
                w_dec_instr_nxt = r_skid_instr;
                w_dec_pc_nxt    = r_skid_pc;
                if (r_inflight_valid) begin
                    w_skid_instr_nxt = imem_rdata;
                    w_skid_pc_nxt    = r_inflight_pc;
                end else begin
                    w_skid_valid_nxt = 1'b0;
                end
            end else if (r_inflight_valid) begin
                w_dec_valid_nxt = 1'b1;
                w_dec_instr_nxt = imem_rdata;
                w_dec_pc_nxt    = r_inflight_pc;
            end else begin
                w_dec_valid_nxt = 1'b0;
            end
        end else if (r_inflight_valid) begin
            // Output held by a stalled decode: park the arriving word.
            w_skid_valid_nxt = 1'b1;
            w_skid_instr_nxt = imem_rdata;
            w_skid_pc_nxt    = r_inflight_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc       <= RESET_PC;
            r_inflight_valid <= 1'b0;
            r_inflight_pc    <= 32'h0;
        end else if (redirect_valid) begin
            r_fetch_pc       <= {redirect_pc[31:2], 2'b00};
            r_inflight_valid <= 1'b0;
        end else if (w_issue) begin
            r_inflight_valid <= 1'b1;
            r_inflight_pc    <= r_fetch_pc;
            r_fetch_pc       <= r_fetch_pc + c_pc_step;
        end else begin
            r_inflight_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dec_valid  <= 1'b0;
            r_dec_instr  <= 32'h0;
            r_dec_pc     <= 32'h0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= 32'h0;
            r_skid_pc    <= 32'h0;
        end else begin
            r_dec_valid  <= w_dec_valid_nxt;
            r_dec_instr  <= w_dec_instr_nxt;
            r_dec_pc     <= w_dec_pc_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
        end
    end

endmodule
`default_nettype wire
